pwm_multi: RTL
==============

Name: pwm_multi

Overview:
Multi-channel PWM generator: one shared period counter drives CHANNELS independent comparators.
- Generalises the single-channel free-running PWM with a runtime-programmable period and per-channel duty.
- Duty and period updates are double-buffered and glitch-free, applied only at period boundaries.
- Supports edge-aligned and center-aligned counting, plus per-channel output polarity.
- Drives LED/backlight dimming and similar display-side outputs.

Parameters:
- CHANNELS, 4, number of PWM outputs (1..16).
- CNT_WIDTH, 16, width of counter, period and each duty value.
- DEFAULT_PERIOD, 999, active/shadow period after reset (must fit in CNT_WIDTH).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = counter runs; 0 = counter held, outputs idle.
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled only at period boundary.
- period_in  in  CNT_WIDTH  new period value P, captured on load.
- duty_in  in  CHANNELS*CNT_WIDTH  packed duties; channel i is bits [i*CNT_WIDTH +: CNT_WIDTH]; captured on load.
- load  in  1  single-cycle strobe; captures period_in/duty_in into shadow registers.
- invert  in  CHANNELS  per-channel polarity; applied live, not buffered.
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_start  out  1  registered one-cycle pulse at the start of each period.
- load_pending  out  1  shadow holds values not yet applied.

Behaviour:
- Reset (async, reset=0):
  - count=0, dir=up, active and shadow period = DEFAULT_PERIOD, active and shadow duties = 0, active mode = edge.
  - load_pending=0, pwm_out=0, period_start=0.
- Counting, edge mode: count goes 0,1,..,P, then 0 again. Period length is P+1 cycles.
- Counting, center mode: count rises 0..P, then falls P-1..1, then returns to 0. Period length is 2P cycles.
- P=0 in either mode: count stays 0, and every cycle is a period boundary.
- Raw compare: raw[i] = (count < duty[i]).
  - Edge mode: duty=0 gives constant low; duty>P gives constant high; duty=d with 0<d≤P gives d high cycles per period.
  - Center mode: high time is 2d-1 cycles for 1≤d≤P, symmetric around count=0.
- Output: pwm_out[i] <= raw[i] XOR invert[i]. Latency is 1 cycle: pwm_out at cycle t+1 reflects count at cycle t.
- period_start is registered alongside pwm_out. It is 1 for the cycle whose compared count is 0, but only while enable=1.
- Boundary is the cycle in which count==0 is being compared. The next count value is computed from the active period/mode at that boundary.
- Shadow update:
  - load=1 captures period_in/duty_in into shadow and sets load_pending.
  - At a boundary with load_pending=1, shadow is copied to active, center_mode is latched into active mode, dir=up, and load_pending is cleared.
  - The compare in the boundary cycle itself already uses the new active values.
- Load coincident with boundary: the boundary transfers the pre-load shadow contents. The new values land in shadow, load_pending stays 1, and they apply at the next boundary.
- Back-to-back loads: the last load before a boundary wins.
- enable=0:
  - count=0, dir=up, period_start=0, pwm_out[i]=invert[i].
  - Shadow transfers one cycle after load, without waiting for a boundary.
- enable 0→1: counting starts at count=0 with period_start=1 in the first enabled output cycle.
- Mid-period reset: all state returns to reset values immediately; no partial period is completed.
- Arithmetic is unsigned, CNT_WIDTH bits. Counter never exceeds active P.
- Reducing P below the current count is impossible, because transfer happens only at count==0.

Decomposition:
- Package pwm_pkg:
  - mode constants PWM_EDGE=1'b0, PWM_CENTER=1'b1.
  - direction constants DIR_UP/DIR_DOWN.
  - helper localparam for packed-duty slice width.
- Sub-module pwm_channel, instantiated CHANNELS times by generate. It holds the active duty register, the compare, the polarity XOR and the output register, with inputs count, shadow duty, transfer strobe and enable.
- Counter, direction, mode, period shadow and handshake live in pwm_multi.

Test Plan:
- CHANNELS=2, CNT_WIDTH=8. After reset, set enable=1, load P=9, duties {3,0}, mode edge → from the 2nd boundary: ch0 high 3 of every 10 cycles, ch1 constant 0, period_start every 10 cycles.
- Edge mode, P=9, duty 10 and duty 255 → constant high. Then invert=2'b11 → both constant low one cycle later.
- Center mode, P=4, duty 2 → period 8 cycles, ch0 high 3 consecutive cycles centred on count=0, period_start every 8 cycles.
- Mid-period load of P=4, duty 1 at count=5 (old P=9) → outputs unchanged until count returns to 0. load_pending is 1 until then. The new 5-cycle period starts exactly at the boundary.
- Load asserted in the boundary cycle → previous shadow is applied, load_pending remains 1, new values apply one period later.
- enable=0 with invert=2'b01 → pwm_out=2'b01, period_start=0, and a load reaches active without a boundary. Async reset mid-period → all outputs 0 immediately, count restarts at 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode/direction encodings and duty-slice helper for the multi-channel PWM.
package pwm_pkg;
    localparam logic PWM_EDGE   = 1'b0;
    localparam logic PWM_CENTER = 1'b1;
    localparam int   PWM_MAX_CHANNELS = 16;
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} pwm_dir_e;
    // LSB of channel ch inside a packed duty vector with w-bit slices
    function automatic int duty_lsb(input int ch, input int w);
        return ch * w;
    endfunction
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM comparator with its active duty register and registered, polarity-adjusted output.
//   clock, reset        : clock and async active-low reset
//   enable              : 0 forces the output to its idle (invert) level
//   count               : shared period counter value being compared this cycle
//   shadow_duty         : buffered duty, copied to the active duty on transfer
//   transfer            : shadow-to-active strobe; the compare in this cycle already uses the new duty
//   invert              : live output polarity
//   pwm_out             : registered PWM output
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] count,
    input  logic [CNT_WIDTH-1:0] shadow_duty,
    input  logic                 transfer,
    input  logic                 invert,
    output logic                 pwm_out
);
    logic [CNT_WIDTH-1:0] duty_q, duty_d;
    logic                 out_q, out_d;

    always_comb begin
        duty_d = transfer ? shadow_duty : duty_q;
        out_d  = enable ? ((count < duty_d) ^ invert) : invert;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            duty_q <= '0;
            out_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            out_q  <= out_d;
        end
    end

    assign pwm_out = out_q;
endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with a shared edge/center-aligned counter and boundary-synchronised double buffering.
//   clock, reset        : clock and async active-low reset
//   enable              : 1 runs the counter; 0 holds count at 0 and idles outputs
//   center_mode         : counting mode, taken into the active mode on transfer
//   period_in, duty_in  : new period and packed per-channel duties, captured by load
//   load                : single-cycle strobe into the shadow registers
//   invert              : per-channel live polarity
//   pwm_out             : registered PWM outputs
//   period_start        : registered pulse for the cycle comparing count 0
//   load_pending        : shadow holds values not yet applied
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int          CHANNELS       = 4,
    parameter int          CNT_WIDTH      = 16,
    parameter int unsigned DEFAULT_PERIOD = 999
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          center_mode,
    input  logic [CNT_WIDTH-1:0]          period_in,
    input  logic [CHANNELS*CNT_WIDTH-1:0] duty_in,
    input  logic                          load,
    input  logic [CHANNELS-1:0]           invert,
    output logic [CHANNELS-1:0]           pwm_out,
    output logic                          period_start,
    output logic                          load_pending
);
    localparam logic [CNT_WIDTH-1:0] ONE = 1;
    localparam logic [CNT_WIDTH-1:0] DEF = CNT_WIDTH'(DEFAULT_PERIOD);

    logic [CNT_WIDTH-1:0]          count_q, count_d, period_q, period_d, sh_period_q, sh_period_d;
    logic [CHANNELS*CNT_WIDTH-1:0] sh_duty_q, sh_duty_d;
    pwm_dir_e                      dir_q, dir_d;
    logic                          mode_q, mode_d, pending_q, pending_d, start_q, start_d;
    logic                          transfer;

    always_comb begin
        // While disabled every cycle may transfer; while running only the count==0 cycle can
        transfer    = pending_q && (!enable || count_q == '0);
        period_d    = transfer ? sh_period_q : period_q;
        mode_d      = transfer ? center_mode : mode_q;
        sh_period_d = load ? period_in : sh_period_q;
        sh_duty_d   = load ? duty_in : sh_duty_q;
        // A load in the transfer cycle lands after the transfer and stays pending
        pending_d   = load || (pending_q && !transfer);
        start_d     = enable && count_q == '0;
        count_d     = '0;
        dir_d       = DIR_UP;
        if (enable && period_d != '0) begin
            if (mode_d == PWM_EDGE) begin
                count_d = (count_q >= period_d) ? '0 : count_q + ONE;
            end else if (dir_q == DIR_UP) begin
                count_d = (count_q >= period_d) ? period_d - ONE : count_q + ONE;
                dir_d   = (count_q >= period_d && period_d > ONE) ? DIR_DOWN : DIR_UP;
            end else begin
                count_d = count_q - ONE;
                dir_d   = (count_q <= ONE) ? DIR_UP : DIR_DOWN;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            dir_q       <= DIR_UP;
            mode_q      <= PWM_EDGE;
            period_q    <= DEF;
            sh_period_q <= DEF;
            sh_duty_q   <= '0;
            pending_q   <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            count_q     <= count_d;
            dir_q       <= dir_d;
            mode_q      <= mode_d;
            period_q    <= period_d;
            sh_period_q <= sh_period_d;
            sh_duty_q   <= sh_duty_d;
            pending_q   <= pending_d;
            start_q     <= start_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
            .clock      (clock),
            .reset      (reset),
            .enable     (enable),
            .count      (count_q),
            .shadow_duty(sh_duty_q[duty_lsb(i, CNT_WIDTH) +: CNT_WIDTH]),
            .transfer   (transfer),
            .invert     (invert[i]),
            .pwm_out    (pwm_out[i])
        );
    end

    assign period_start = start_q;
    assign load_pending = pending_q;
endmodule
